// File: rtl/except_commit.sv
// except_commit: registered exception/interrupt prioritiser and commit stage with drain suppression
module except_commit #(
  parameter int          NUM_HW_INT   = 6,
  parameter int          SYNC_STAGES  = 2,
  parameter int          FLUSH_CYCLES = 3,
  parameter logic [31:0] EXC_VEC      = 32'hBFC00380,
  parameter logic [31:0] REFILL_VEC   = 32'hBFC00200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_HW_INT-1:0] hw_int,
  input  logic                  valid_m,
  input  logic                  stall_m,
  input  logic [31:0]           pc_m,
  input  logic                  in_ds_m,
  input  logic [31:0]           bad_addr_m,
  input  logic [14:0]           src_m,
  input  logic [31:0]           cp0_status,
  input  logic [31:0]           cp0_cause,
  input  logic [31:0]           cp0_epc,
  output logic [31:0]           excepttype,
  output logic                  flush,
  output logic [31:0]           new_pc,
  output logic [31:0]           epc_out,
  output logic [31:0]           badvaddr_out,
  output logic                  badv_we,
  output logic                  bd_out,
  output logic                  exc_we,
  output logic                  eret_out,
  output logic                  int_pending
);
  typedef enum logic {IDLE, DRAIN} state_t;
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [74:0] CODES = {5'h14, 5'h13, 5'h12, 5'h0c, 5'h0b, 5'h0a, 5'h0d, 5'h0e,
                                   5'h09, 5'h08, 5'h11, 5'h10, 5'h05, 5'h04, 5'h04};
  localparam logic [14:0] BADV    = 15'h701f;
  localparam logic [14:0] BADV_PC = 15'h0019;
  state_t                state;
  logic [CW-1:0]         cnt;
  logic [NUM_HW_INT-1:0] sync_q [SYNC_STAGES];
  logic [7:0]            ip;
  logic [4:0]            code;
  logic                  int_now, take, is_badv, badv_pc, eret, refill;
  always_comb begin
    ip = 8'({sync_q[SYNC_STAGES-1], cp0_cause[9:8]});
    int_now = |(ip & cp0_status[15:8]) & ~cp0_status[1] & cp0_status[0];
    take = (state == IDLE) & valid_m & ~stall_m & (int_now | (|src_m));
    code = 5'h01;
    is_badv = 1'b0;
    badv_pc = 1'b0;
    if (!int_now)
      for (int i = 14; i >= 0; i--)
        if (src_m[i]) begin
          code = CODES[i*5 +: 5];
          is_badv = BADV[i];
          badv_pc = BADV_PC[i];
        end
    eret = code == 5'h0e;
    refill = (code == 5'h10 || code == 5'h12) && !cp0_status[1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      int_pending <= 1'b0;
      flush <= 1'b0;
      exc_we <= 1'b0;
      eret_out <= 1'b0;
      badv_we <= 1'b0;
      bd_out <= 1'b0;
      excepttype <= '0;
      new_pc <= '0;
      epc_out <= '0;
      badvaddr_out <= '0;
    end else begin
      sync_q[0] <= hw_int;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      int_pending <= int_now;
      flush <= take;
      exc_we <= take & ~eret;
      eret_out <= take & eret;
      badv_we <= take & is_badv;
      bd_out <= take & ~eret & in_ds_m;
      excepttype <= take ? {27'b0, code} : '0;
      new_pc <= !take ? '0 : eret ? cp0_epc : refill ? REFILL_VEC : EXC_VEC;
      epc_out <= (take && !eret) ? (in_ds_m ? pc_m - 32'd4 : pc_m) : '0;
      badvaddr_out <= (take && is_badv) ? (badv_pc ? pc_m : bad_addr_m) : '0;
      if (take) begin
        state <= DRAIN;
        cnt <= CW'(FLUSH_CYCLES - 1);
      end else if (state == DRAIN) begin
        if (cnt == '0) state <= IDLE;
        else cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: doc/except_commit.md
Name: except_commit

Overview:
- Parametrised, registered successor to the combinational exception prioritiser.
- Sits at the memory/commit stage: synchronises external interrupt lines and arbitrates 15 exception sources plus interrupt by fixed priority.
- Commits one exception per instruction and produces a one-cycle flush, the redirect PC and the CP0 write data (EPC, BadVAddr, BD, ExcCode).
- After each commit, suppresses further commits while the pipeline drains.

Parameters:
- NUM_HW_INT, 6, external interrupt lines (1..6), mapped to Cause.IP[NUM_HW_INT+1:2].
- SYNC_STAGES, 2, flip-flop stages in the hw_int synchroniser (>=2).
- FLUSH_CYCLES, 3, DRAIN length after a commit (>=1).
- EXC_VEC, 32'hBFC00380, general exception entry.
- REFILL_VEC, 32'hBFC00200, TLB refill entry.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- hw_int  in  NUM_HW_INT  asynchronous interrupt requests, level
- valid_m  in  1  instruction present in M stage
- stall_m  in  1  M stage stalled
- pc_m  in  32  M-stage PC
- in_ds_m  in  1  M-stage instruction is in a delay slot
- bad_addr_m  in  32  data address of the M-stage access
- src_m  in  15  exception sources; priority bit0 highest
- cp0_status  in  32  Status
- cp0_cause  in  32  Cause (only IP[1:0] is used)
- cp0_epc  in  32  EPC
- excepttype  out  32  committed code; valid only with flush
- flush  out  1  one-cycle pipeline flush
- new_pc  out  32  redirect target
- epc_out  out  32  EPC write data
- badvaddr_out  out  32  BadVAddr write data
- badv_we  out  1  BadVAddr write enable
- bd_out  out  1  Cause.BD write data
- exc_we  out  1  CP0 exception write strobe
- eret_out  out  1  ERET commit pulse (clear EXL)
- int_pending  out  1  registered interrupt-pending flag

Behaviour:
- Reset: rst is synchronous, active-high. While rst is high, every output and synchroniser flop is 0, the FSM is IDLE and the counter is 0. Reset applied mid-DRAIN aborts the drain.

Source map (code):
- bit0 ADEL fetch (0x04, badv=pc_m)
- bit1 ADEL load (0x04, badv=bad_addr_m)
- bit2 ADES (0x05, badv=bad_addr_m)
- bit3 ITLB refill (0x10, badv=pc_m)
- bit4 ITLB invalid (0x11, badv=pc_m)
- bit5 syscall (0x08)
- bit6 break (0x09)
- bit7 eret (0x0e)
- bit8 trap (0x0d)
- bit9 reserved instruction (0x0a)
- bit10 CpU (0x0b)
- bit11 overflow (0x0c)
- bit12 DTLB refill (0x12, badv=bad_addr_m)
- bit13 DTLB invalid (0x13, badv=bad_addr_m)
- bit14 TLB modified (0x14, badv=bad_addr_m)

Interrupt:
- ip = {sync(hw_int), cp0_cause[9:8]}, zero-extended to 8 bits.
- int_now = |(ip & status[15:8]) & ~status[1] & status[0].
- int_pending <= int_now every cycle.
- Interrupt (0x01) outranks all src_m bits.

FSM IDLE:
- take = valid_m & ~stall_m & (int_now | |src_m).
- When take is high, at the next edge register the winner, pulse flush=1 for 1 cycle and go to DRAIN with cnt=FLUSH_CYCLES-1.
- When take is low, flush, exc_we, eret_out and badv_we are 0 and excepttype is 0.
- Stall holding a pending exception: no commit; the decision is re-evaluated each cycle.

Commit outputs (latency 1):
- Non-eret winner: exc_we=1, epc_out = in_ds_m ? pc_m-4 : pc_m, bd_out=in_ds_m.
- badv_we=1 only for the codes marked badv above.
- new_pc = REFILL_VEC when the code is 0x10 or 0x12 and status[1]=0; otherwise EXC_VEC.
- eret winner: exc_we=0, eret_out=1, new_pc=cp0_epc, excepttype=0x0e.

FSM DRAIN:
- All inputs except hw_int are ignored.
- cnt decrements each cycle; return to IDLE when cnt==0.
- The first instruction that can commit is evaluated in the cycle after the return.
- Pulse outputs are 0 throughout DRAIN.

Width rules:
- pc_m-4 wraps modulo 2^32.
- Unused IP bits (when NUM_HW_INT<6) read as 0.

Test Plan:
- src_m=15'h0021 (ADEL fetch + syscall), pc_m=32'h80001004, in_ds_m=1 -> next cycle flush=1, excepttype=0x04, epc_out=32'h80001000, bd_out=1, badvaddr_out=32'h80001004, new_pc=32'hBFC00380.
- Interrupt: status=32'h0000_0401, hw_int[0]=1 held, valid_m=1, src_m=bit11 -> flush with excepttype=0x01 exactly SYNC_STAGES+1 cycles after hw_int rises. Repeat with status[1]=1 -> overflow 0x0c.
- DTLB refill, status[1]=0, bad_addr_m=32'h00400010 -> excepttype=0x12, new_pc=32'hBFC00200, badv_we=1. Repeat with status[1]=1 -> new_pc=32'hBFC00380.
- eret: src_m=bit7, cp0_epc=32'hBFC00100 -> eret_out=1, exc_we=0, new_pc=32'hBFC00100.
- Stall and drain: break held with stall_m=1 for 4 cycles -> no flush. Release stall -> one flush. New exceptions presented during the following FLUSH_CYCLES=3 cycles -> ignored; the exception in cycle 4 after flush -> commits.
- rst asserted in the 2nd DRAIN cycle -> all outputs 0 next edge. An exception presented right after rst is released commits normally.
